// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: the FSM state encoding
// and the operand forwarding selector codes.
package hazard_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      FAULT    = 2'd2
   } hazard_state_e;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/hazard_fwd_sel.sv
// Per-operand forwarding comparator: picks the youngest in-flight producer
// (M before W) of the E-stage source register.
module hazard_fwd_sel
   import hazard_pkg::*;
#(
   parameter int ADDRESSWIDTH = 4,
   parameter bit ZERO_REG     = 1'b1
) (
   input  logic [ADDRESSWIDTH-1:0] readAddressE,
   input  logic                    writeEnableM,
   input  logic [ADDRESSWIDTH-1:0] writeAddressM,
   input  logic                    writeEnableW,
   input  logic [ADDRESSWIDTH-1:0] writeAddressW,
   output logic [1:0]              selector
);

   logic is_zero;
   logic hit_m;
   logic hit_w;

   // A hard-wired zero register always reads as zero, so it is never forwarded.
   assign is_zero = ZERO_REG && (readAddressE == '0);
   assign hit_m   = writeEnableM && (writeAddressM == readAddressE);
   assign hit_w   = writeEnableW && (writeAddressW == readAddressE);

   always_comb begin
      selector = FWD_RF;
      if (!is_zero) begin
         if (hit_m) begin
            selector = FWD_MEM;
         end else if (hit_w) begin
            selector = FWD_WB;
         end
      end
   end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: forwarding, load-use stall, branch flush and a
// data-memory wait FSM with timeout fault. Optional HAZARD_PERF_COUNTERS_EN.
module hazard_ctrl_unit
   import hazard_pkg::*;
#(
   parameter int ADDRESSWIDTH = 4,
   parameter bit ZERO_REG     = 1'b1,
   parameter int WAIT_TIMEOUT = 15
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    writeEnableM,
   input  logic                    writeEnableDWB,
   input  logic [ADDRESSWIDTH-1:0] writeAddressE,
   input  logic [ADDRESSWIDTH-1:0] writeAddressM,
   input  logic [ADDRESSWIDTH-1:0] writeAddressW,
   input  logic [ADDRESSWIDTH-1:0] reg1ReadAddressD,
   input  logic [ADDRESSWIDTH-1:0] reg2ReadAddressD,
   input  logic [ADDRESSWIDTH-1:0] reg1ReadAddressE,
   input  logic [ADDRESSWIDTH-1:0] reg2ReadAddressE,
   input  logic                    resultSelectorWBE,
   input  logic                    loadM,
   input  logic                    memReadyM,
   input  logic                    takeBranchE,
   output logic [1:0]              data1ForwardSelectorE,
   output logic [1:0]              data2ForwardSelectorE,
   output logic                    stallF,
   output logic                    stallD,
   output logic                    stallE,
   output logic                    stallM,
   output logic                    flushD,
   output logic                    flushE,
   output logic                    flushW,
`ifdef HAZARD_PERF_COUNTERS_EN
   output logic [31:0]             stallCycles,
   output logic [31:0]             flushCycles,
`endif
   output logic                    memFault
);

   localparam int CW = $clog2(WAIT_TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_LIMIT = CW'(WAIT_TIMEOUT);

   hazard_state_e state_q, state_d;
   logic [CW-1:0] wait_cnt_q, wait_cnt_d;

   logic [ADDRESSWIDTH-1:0] rd_addr_e [2];
   logic [1:0]              fwd_sel   [2];

   assign rd_addr_e[0] = reg1ReadAddressE;
   assign rd_addr_e[1] = reg2ReadAddressE;

   for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      hazard_fwd_sel #(
         .ADDRESSWIDTH (ADDRESSWIDTH),
         .ZERO_REG     (ZERO_REG)
      ) u_fwd_sel (
         .readAddressE  (rd_addr_e[gi]),
         .writeEnableM  (writeEnableM),
         .writeAddressM (writeAddressM),
         .writeEnableW  (writeEnableDWB),
         .writeAddressW (writeAddressW),
         .selector      (fwd_sel[gi])
      );
   end

   assign data1ForwardSelectorE = reset ? FWD_RF : fwd_sel[0];
   assign data2ForwardSelectorE = reset ? FWD_RF : fwd_sel[1];

   logic lduse_1, lduse_2, lduse;
   assign lduse_1 = (reg1ReadAddressD == writeAddressE) &&
                    !(ZERO_REG && (reg1ReadAddressD == '0));
   assign lduse_2 = (reg2ReadAddressD == writeAddressE) &&
                    !(ZERO_REG && (reg2ReadAddressD == '0));
   assign lduse   = resultSelectorWBE && (lduse_1 || lduse_2);

   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      stallF     = 1'b0;
      stallD     = 1'b0;
      stallE     = 1'b0;
      stallM     = 1'b0;
      flushD     = 1'b0;
      flushE     = 1'b0;
      flushW     = 1'b0;
      memFault   = 1'b0;
      case (state_q)
         RUN: begin
            stallF = lduse;
            stallD = lduse;
            flushE = lduse | takeBranchE;
            flushD = takeBranchE;
            // The missing load must stay in M during the cycle the miss is seen.
            if (loadM && !memReadyM) begin
               stallM     = 1'b1;
               state_d    = MEM_WAIT;
               wait_cnt_d = CW'(1);
            end
         end
         MEM_WAIT: begin
            stallF = 1'b1;
            stallD = 1'b1;
            stallE = 1'b1;
            stallM = 1'b1;
            flushW = 1'b1;
            if (memReadyM) begin
               state_d    = RUN;
               wait_cnt_d = '0;
            end else if (wait_cnt_q >= CNT_LIMIT) begin
               state_d = FAULT;
            end else begin
               wait_cnt_d = wait_cnt_q + CW'(1);
            end
         end
         FAULT: begin
            stallF   = 1'b1;
            stallD   = 1'b1;
            stallE   = 1'b1;
            stallM   = 1'b1;
            flushW   = 1'b1;
            memFault = 1'b1;
         end
         default: begin
            state_d    = RUN;
            wait_cnt_d = '0;
         end
      endcase
      // Reset turns every stage into a bubble regardless of state.
      if (reset) begin
         state_d    = RUN;
         wait_cnt_d = '0;
         stallF     = 1'b0;
         stallD     = 1'b0;
         stallE     = 1'b0;
         stallM     = 1'b0;
         flushD     = 1'b1;
         flushE     = 1'b1;
         flushW     = 1'b1;
         memFault   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
   end

`ifdef HAZARD_PERF_COUNTERS_EN
   logic [31:0] stall_cycles_q, stall_cycles_d;
   logic [31:0] flush_cycles_q, flush_cycles_d;

   always_comb begin
      stall_cycles_d = stall_cycles_q;
      flush_cycles_d = flush_cycles_q;
      if (reset) begin
         stall_cycles_d = '0;
         flush_cycles_d = '0;
      end else begin
         if (stallF && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
         end
         if (flushE && (flush_cycles_q != '1)) begin
            flush_cycles_d = flush_cycles_q + 32'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      stall_cycles_q <= stall_cycles_d;
      flush_cycles_q <= flush_cycles_d;
   end

   assign stallCycles = stall_cycles_q;
   assign flushCycles = flush_cycles_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed scoreboard bench for hazard_ctrl_unit (ZERO_REG=1, WAIT_TIMEOUT=4).
module tb_hazard_ctrl_unit;

   localparam int AW = 4;

   logic          clk;
   logic          reset;
   logic          writeEnableM, writeEnableDWB;
   logic [AW-1:0] writeAddressE, writeAddressM, writeAddressW;
   logic [AW-1:0] reg1ReadAddressD, reg2ReadAddressD;
   logic [AW-1:0] reg1ReadAddressE, reg2ReadAddressE;
   logic          resultSelectorWBE, loadM, memReadyM, takeBranchE;
   logic [1:0]    data1ForwardSelectorE, data2ForwardSelectorE;
   logic          stallF, stallD, stallE, stallM;
   logic          flushD, flushE, flushW, memFault;
`ifdef HAZARD_PERF_COUNTERS_EN
   logic [31:0]   stallCycles, flushCycles;
`endif

   int n_cmp = 0;
   int n_err = 0;
   logic [11:0] exp_q [$];
   string       tag_q [$];
   logic [11:0] obs;

   hazard_ctrl_unit #(
      .ADDRESSWIDTH (AW),
      .ZERO_REG     (1'b1),
      .WAIT_TIMEOUT (4)
   ) dut (
      .clk                   (clk),
      .reset                 (reset),
      .writeEnableM          (writeEnableM),
      .writeEnableDWB        (writeEnableDWB),
      .writeAddressE         (writeAddressE),
      .writeAddressM         (writeAddressM),
      .writeAddressW         (writeAddressW),
      .reg1ReadAddressD      (reg1ReadAddressD),
      .reg2ReadAddressD      (reg2ReadAddressD),
      .reg1ReadAddressE      (reg1ReadAddressE),
      .reg2ReadAddressE      (reg2ReadAddressE),
      .resultSelectorWBE     (resultSelectorWBE),
      .loadM                 (loadM),
      .memReadyM             (memReadyM),
      .takeBranchE           (takeBranchE),
      .data1ForwardSelectorE (data1ForwardSelectorE),
      .data2ForwardSelectorE (data2ForwardSelectorE),
      .stallF                (stallF),
      .stallD                (stallD),
      .stallE                (stallE),
      .stallM                (stallM),
      .flushD                (flushD),
      .flushE                (flushE),
      .flushW                (flushW),
`ifdef HAZARD_PERF_COUNTERS_EN
      .stallCycles           (stallCycles),
      .flushCycles           (flushCycles),
`endif
      .memFault              (memFault)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   assign obs = {data1ForwardSelectorE, data2ForwardSelectorE,
                 stallF, stallD, stallE, stallM, flushD, flushE, flushW, memFault};

   // ctl = {stallF, stallD, stallE, stallM, flushD, flushE, flushW, memFault}
   task automatic cyc(input string tag, input logic [1:0] f1, input logic [1:0] f2,
                      input logic [7:0] ctl);
      logic [11:0] e;
      string       t;
      exp_q.push_back({f1, f2, ctl});
      tag_q.push_back(tag);
      @(negedge clk);
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      n_cmp++;
      assert (obs === e) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", t, obs, e);
      end
      $display("txn %-14s observed=%h expected=%h", t, obs, e);
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      writeEnableM = 0; writeEnableDWB = 0;
      writeAddressE = 0; writeAddressM = 0; writeAddressW = 0;
      reg1ReadAddressD = 0; reg2ReadAddressD = 0;
      reg1ReadAddressE = 0; reg2ReadAddressE = 0;
      resultSelectorWBE = 0; loadM = 0; memReadyM = 0; takeBranchE = 0;
   endtask

`ifdef HAZARD_PERF_COUNTERS_EN
   task automatic chk32(input string tag, input logic [31:0] o, input logic [31:0] e);
      n_cmp++;
      assert (o === e) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
      end
      $display("txn %-14s observed=%0d expected=%0d", tag, o, e);
   endtask
`endif

   localparam logic [7:0] C_RUN   = 8'b0000_0000;
   localparam logic [7:0] C_RST   = 8'b0000_1110;
   localparam logic [7:0] C_WAIT  = 8'b1111_0010;
   localparam logic [7:0] C_FAULT = 8'b1111_0011;

   initial begin
      clear_inputs();
      reset = 1'b1;
      writeEnableM = 1; writeAddressM = 3; reg1ReadAddressE = 3;
      cyc("reset0", 2'b00, 2'b00, C_RST);
      cyc("reset1", 2'b00, 2'b00, C_RST);

      // Forwarding
      reset = 1'b0;
      writeEnableDWB = 1; writeAddressW = 3;
      cyc("fwd_m", 2'b10, 2'b00, C_RUN);
      writeEnableM = 0;
      cyc("fwd_w", 2'b01, 2'b00, C_RUN);
      writeEnableM = 1; writeAddressM = 0; reg1ReadAddressE = 0; reg2ReadAddressE = 3;
      cyc("fwd_zero", 2'b00, 2'b01, C_RUN);
      writeAddressM = 3;
      cyc("fwd_m_prio2", 2'b00, 2'b10, C_RUN);
      clear_inputs();

      // Load-use and branches
      resultSelectorWBE = 1; writeAddressE = 5; reg2ReadAddressD = 5;
      cyc("lduse", 2'b00, 2'b00, 8'b1100_0100);
      takeBranchE = 1;
      cyc("lduse_br", 2'b00, 2'b00, 8'b1100_1100);
      takeBranchE = 0; writeAddressE = 0; reg2ReadAddressD = 0;
      cyc("lduse_zero", 2'b00, 2'b00, C_RUN);
      resultSelectorWBE = 0; takeBranchE = 1;
      cyc("branch", 2'b00, 2'b00, 8'b0000_1100);
      clear_inputs();

      // Memory wait released by memReadyM
      loadM = 1; memReadyM = 0;
      cyc("miss", 2'b00, 2'b00, 8'b0001_0000);
      takeBranchE = 1;
      cyc("wait1", 2'b00, 2'b00, C_WAIT);
      takeBranchE = 0;
      cyc("wait2", 2'b00, 2'b00, C_WAIT);
      memReadyM = 1;
      cyc("wait3_ready", 2'b00, 2'b00, C_WAIT);
      loadM = 0;
      cyc("run_after", 2'b00, 2'b00, C_RUN);

      // Timeout into FAULT
      loadM = 1; memReadyM = 0;
      cyc("to_miss", 2'b00, 2'b00, 8'b0001_0000);
      for (int i = 1; i <= 4; i++) cyc($sformatf("to_wait%0d", i), 2'b00, 2'b00, C_WAIT);
      cyc("fault", 2'b00, 2'b00, C_FAULT);
      memReadyM = 1;
      cyc("fault_sticky", 2'b00, 2'b00, C_FAULT);
      reset = 1;
      cyc("fault_reset", 2'b00, 2'b00, C_RST);
      reset = 0; loadM = 0; memReadyM = 0;
      cyc("run_post_rst", 2'b00, 2'b00, C_RUN);

      // memReadyM on the timeout cycle wins
      loadM = 1; memReadyM = 0;
      cyc("bd_miss", 2'b00, 2'b00, 8'b0001_0000);
      for (int i = 1; i <= 3; i++) cyc($sformatf("bd_wait%0d", i), 2'b00, 2'b00, C_WAIT);
      memReadyM = 1;
      cyc("bd_wait4_rdy", 2'b00, 2'b00, C_WAIT);
      loadM = 0; memReadyM = 0;
      cyc("bd_run", 2'b00, 2'b00, C_RUN);
      cyc("bd_no_fault", 2'b00, 2'b00, C_RUN);

`ifdef HAZARD_PERF_COUNTERS_EN
      clear_inputs();
      reset = 1;
      cyc("pc_reset", 2'b00, 2'b00, C_RST);
      reset = 0;
      resultSelectorWBE = 1; writeAddressE = 5; reg1ReadAddressD = 5;
      for (int i = 0; i < 3; i++) cyc("pc_lduse", 2'b00, 2'b00, 8'b1100_0100);
      clear_inputs();
      takeBranchE = 1;
      for (int i = 0; i < 2; i++) cyc("pc_branch", 2'b00, 2'b00, 8'b0000_1100);
      clear_inputs();
      @(negedge clk);
      chk32("stallCycles", stallCycles, 32'd3);
      chk32("flushCycles", flushCycles, 32'd5);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl_unit.md
# hazard_ctrl_unit

Second-generation pipeline hazard controller for the 5-stage (F/D/E/M/W) processor. It replaces the purely combinational hazard unit. It adds parametrised register-file width, an optional hard-wired zero register, and a multi-cycle data-memory wait state machine with a timeout fault. It sits beside the pipeline registers and drives their stall/flush enables and the E-stage operand forwarding muxes.

## Interface
- ADDRESSWIDTH, 4: register address width.
- ZERO_REG, 1: when 1, register 0 is never forwarded and never causes a load-use stall.
- WAIT_TIMEOUT, 15: maximum consecutive MEM_WAIT cycles before a fault; must be at least 1.
- clk  in  1  pipeline clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- writeEnableM, writeEnableDWB  in  1  register write enables of the M and W stage instructions.
- writeAddressE, writeAddressM, writeAddressW  in  ADDRESSWIDTH  destination registers.
- reg1ReadAddressD, reg2ReadAddressD, reg1ReadAddressE, reg2ReadAddressE  in  ADDRESSWIDTH  source registers.
- resultSelectorWBE  in  1  the E-stage instruction is a load.
- loadM  in  1  the M-stage instruction is a load.
- memReadyM  in  1  data memory returns load data this cycle.
- takeBranchE  in  1  the branch resolved in E is taken.
- data1ForwardSelectorE, data2ForwardSelectorE  out  2  00 register file, 01 W result, 10 M ALU result.
- stallF, stallD, stallE, stallM  out  1  hold the corresponding pipeline register.
- flushD, flushE, flushW  out  1  clear the corresponding pipeline register to a bubble.
- memFault  out  1  sticky timeout flag.

## Operation
- Forwarding rules (combinational):
  - Per operand, M match (writeEnableM, address equal) gives 10.
  - Otherwise a W match (writeEnableDWB) gives 01.
  - Otherwise 00.
  - With ZERO_REG=1, address 0 always selects 00.
- Load-use stall (combinational): lduse = resultSelectorWBE and (reg1ReadAddressD or reg2ReadAddressD equals writeAddressE). With ZERO_REG=1, address 0 is excluded.
- FSM states: RUN, MEM_WAIT, FAULT.
- RUN:
  - If loadM and !memReadyM, next state is MEM_WAIT and waitCount is set to 1.
  - Outputs in RUN: stallF = stallD = lduse; flushE = lduse | takeBranchE; flushD = takeBranchE; stallE = stallM = flushW = 0.
- MEM_WAIT:
  - stallF, stallD, stallE and stallM are all asserted, and flushW=1.
  - flushD and flushE are 0; takeBranchE is ignored because E is frozen and the branch is re-evaluated after release.
  - memReadyM=1 gives next state RUN, and all outputs take their RUN values in the following cycle.
  - Otherwise waitCount increments. When waitCount reaches WAIT_TIMEOUT with memReadyM=0, next state is FAULT.
- FAULT:
  - All stalls are asserted and flushW=1; the pipeline is frozen.
  - memFault=1.
  - Only reset exits this state.
- Simultaneous events:
  - memReadyM and the timeout in the same cycle: memReadyM wins and the next state is RUN.
  - lduse together with takeBranchE in RUN: stallF and stallD stay asserted, and flushD and flushE are both 1.
- Arithmetic: waitCount is $clog2(WAIT_TIMEOUT+1) bits wide and never wraps.

## Timing
- Forwarding and stall/flush outputs are combinational from the inputs and the current state, with zero-cycle latency.
- The state update takes effect on the next clk edge.
- A load that misses memory on cycle t shows the full stall from cycle t+1. Cycle t itself uses RUN outputs; the M stage input is held because stallM is driven combinationally from (state==RUN and loadM and !memReadyM) as well.
- Reset (synchronous, including mid-MEM_WAIT or in FAULT):
  - Next state is RUN; waitCount=0; memFault=0.
  - Outputs during the reset cycle: all stalls=0, flushD=flushE=flushW=1, and both forward selectors=00.

## Configuration
- HAZARD_PERF_COUNTERS_EN defined: adds the outputs stallCycles and flushCycles (32 bits each, out).
  - stallCycles increments on every cycle with stallF=1.
  - flushCycles increments on every cycle with flushE=1.
  - Both saturate at all-ones and clear on reset.
- Macro not defined: neither port exists, and there is no counter logic.

## Structure
- Shared package hazard_pkg: the state enum (RUN, MEM_WAIT, FAULT) and the forwarding selector constants (FWD_RF, FWD_WB, FWD_MEM).
- One sub-module, hazard_fwd_sel: the per-operand forwarding comparator, instantiated twice.
- The FSM, the wait counter and the optional perf counters live in the top module.

## Test plan
- Forwarding: writeEnableM=1 with writeAddressM=3, writeEnableDWB=1 with writeAddressW=3, and reg1ReadAddressE=3 → data1ForwardSelectorE=10. Drop writeEnableM → 01. Set the address to 0 with ZERO_REG=1 → 00.
- Load-use: resultSelectorWBE=1, writeAddressE=5, reg2ReadAddressD=5 → stallF=stallD=flushE=1 for one cycle. The same case with takeBranchE=1 → flushD=1 as well.
- Memory wait: loadM=1 with memReadyM=0 for 3 cycles, then 1 → state reaches MEM_WAIT, stallE=stallM=flushW=1 for those cycles, and RUN returns the cycle after memReadyM.
- Timeout: WAIT_TIMEOUT=4 with memReadyM held at 0 → memFault=1 after 4 MEM_WAIT cycles and stays set. Then reset=1 for one cycle → memFault=0 and state is RUN.
- Boundary: memReadyM rises exactly on the timeout cycle → no fault and the state returns to RUN.
- With HAZARD_PERF_COUNTERS_EN defined: 3 load-use stalls plus 2 taken branches → stallCycles=3 and flushCycles=5.
